// File: rtl/ocp_slave_fsm_pkg.sv
// Shared definitions for the OCP slave target.
// Holds the MCmd and SResp encodings, the FSM state encoding, the burst-length
// width and a helper that maps a zero burst length onto one beat.
package ocp_slave_fsm_pkg;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'd0,
    MCMD_WR   = 3'd1,
    MCMD_RD   = 3'd2,
    MCMD_RDEX = 3'd3,
    MCMD_RDL  = 3'd4,
    MCMD_WRNP = 3'd5,
    MCMD_WRC  = 3'd6,
    MCMD_BCST = 3'd7
  } mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'd0,
    SRESP_DVA  = 2'd1,
    SRESP_FAIL = 2'd2,
    SRESP_ERR  = 2'd3
  } sresp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_SRESP = 2'd3
  } state_e;

  localparam int BLEN_W = 10;

  // A burst length of zero is treated as a single beat.
  function automatic logic [BLEN_W-1:0] eff_len(input logic [BLEN_W-1:0] len);
    return (len == '0) ? BLEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/ocp_slave_fsm_if.sv
// OCP request/response bundle between a master and ocp_slave_fsm.
//   MCmd/MAddr/MData/MBurstLength/MBurstSingleReq/MReqLast : request (master -> slave)
//   SCmdAccept                                               : request accept (slave -> master)
//   SResp/SData/SRespLast                                    : response (slave -> master)
// Handshake: a request is valid while MCmd != IDLE and the master holds all request
// fields stable until SCmdAccept is seen high; the request transfers on the rising
// edge where MCmd != IDLE and SCmdAccept == 1. Responses are valid whenever
// SResp != NULL and are never throttled (the master has no response accept).
interface ocp_slave_fsm_if
  import ocp_slave_fsm_pkg::*;
#(
  parameter int MADDR_WIDTH = 64,
  parameter int MDATA_WIDTH = 8
);
  logic [2:0]             MCmd;
  logic [MADDR_WIDTH-1:0] MAddr;
  logic [MDATA_WIDTH-1:0] MData;
  logic [BLEN_W-1:0]      MBurstLength;
  logic                   MBurstSingleReq;
  logic                   MReqLast;
  logic                   SCmdAccept;
  logic [1:0]             SResp;
  logic [MDATA_WIDTH-1:0] SData;
  logic                   SRespLast;

  modport master (
    output MCmd, MAddr, MData, MBurstLength, MBurstSingleReq, MReqLast,
    input  SCmdAccept, SResp, SData, SRespLast
  );

  modport slave (
    input  MCmd, MAddr, MData, MBurstLength, MBurstSingleReq, MReqLast,
    output SCmdAccept, SResp, SData, SRespLast
  );
endinterface

// File: rtl/ocp_slave_mem.sv
// Backing store for the OCP slave: DEPTH x WIDTH flops.
//   clk, rst          : clock, asynchronous active-high clear of every word
//   we, waddr, wdata  : synchronous write port
//   raddr, rdata      : asynchronous (combinational) read port
module ocp_slave_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ocp_slave_fsm.sv
// OCP slave target backed by a small register memory.
// Accepts single requests, multi-request bursts and single-request read bursts,
// answers reads with DVA/ERR and posts writes without a response.
//   sys_clk, reset : clock, asynchronous active-high reset
//   bus            : OCP request/response bundle (slave side)
//   protocol_err   : sticky flag for MReqLast/beat-count mismatch or single-request write
//   state_dbg      : current FSM state
module ocp_slave_fsm
  import ocp_slave_fsm_pkg::*;
#(
  parameter int MADDR_WIDTH    = 64,
  parameter int MDATA_WIDTH    = 8,
  parameter int MEM_DEPTH      = 16,
  parameter int ADDR_LSB       = 2,
  parameter int ACCEPT_LATENCY = 0
) (
  input  logic            sys_clk,
  input  logic            reset,
  ocp_slave_fsm_if.slave  bus,
  output logic            protocol_err,
  output state_e          state_dbg
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
  localparam logic [BLEN_W-1:0] LEN_ONE = BLEN_W'(1);
  localparam logic [3:0]        LAT     = 4'(ACCEPT_LATENCY);

  // Request decode
  mcmd_e             cmd;
  logic [IDX_W-1:0]  req_idx;
  logic              req_oor;
  logic [BLEN_W-1:0] req_len;

  assign cmd     = mcmd_e'(bus.MCmd);
  assign req_idx = bus.MAddr[ADDR_LSB +: IDX_W];
  // Any address bit above the word index puts the request outside the memory.
  assign req_oor = (bus.MAddr >> (ADDR_LSB + IDX_W)) != '0;
  assign req_len = eff_len(bus.MBurstLength);

  // State and response registers
  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [BLEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]  srq_idx_q, srq_idx_d;
  logic              srq_oor_q, srq_oor_d;
  sresp_e            sresp_q, sresp_d;
  logic [MDATA_WIDTH-1:0] sdata_q, sdata_d;
  logic              slast_q, slast_d;
  logic              perr_q, perr_d;

  // Combinational helpers
  logic accept, in_burst, multi, exp_last, resp_last;
  logic mem_we;
  logic [IDX_W-1:0] mem_raddr;
  logic [MDATA_WIDTH-1:0] mem_rdata;

  ocp_slave_mem #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (MDATA_WIDTH)
  ) u_mem (
    .clk   (sys_clk),
    .rst   (reset),
    .we    (mem_we),
    .waddr (req_idx),
    .wdata (bus.MData),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
      srq_idx_q  <= '0;
      srq_oor_q  <= 1'b0;
      sresp_q    <= SRESP_NULL;
      sdata_q    <= '0;
      slast_q    <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      srq_idx_q  <= srq_idx_d;
      srq_oor_q  <= srq_oor_d;
      sresp_q    <= sresp_d;
      sdata_q    <= sdata_d;
      slast_q    <= slast_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    srq_idx_d  = srq_idx_q;
    srq_oor_d  = srq_oor_q;
    sresp_d    = SRESP_NULL;   // responses last exactly one cycle
    sdata_d    = '0;
    slast_d    = 1'b0;
    perr_d     = perr_q;
    accept     = 1'b0;
    in_burst   = 1'b0;
    multi      = 1'b0;
    exp_last   = 1'b0;
    resp_last  = 1'b1;
    mem_we     = 1'b0;
    mem_raddr  = req_idx;

    case (state_q)
      ST_IDLE: begin
        if (cmd != MCMD_IDLE) begin
          if (ACCEPT_LATENCY == 0) begin
            accept = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (cmd == MCMD_IDLE) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == LAT) begin
          accept = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_BURST: begin
        // Follow-on requests of a multi-request burst never wait.
        if (cmd != MCMD_IDLE) begin
          accept   = 1'b1;
          in_burst = 1'b1;
        end
      end
      ST_SRESP: begin
        // beat_cnt holds the beats still owed; the request port is closed.
        mem_raddr  = srq_idx_q;
        sresp_d    = srq_oor_q ? SRESP_ERR : SRESP_DVA;
        sdata_d    = srq_oor_q ? '0 : mem_rdata;
        slast_d    = (beat_cnt_q <= LEN_ONE);
        beat_cnt_d = beat_cnt_q - LEN_ONE;
        srq_idx_d  = srq_idx_q + IDX_ONE;
        if (beat_cnt_q <= LEN_ONE) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      wait_cnt_d = '0;
      state_d    = ST_IDLE;
      multi      = in_burst || (!bus.MBurstSingleReq && (req_len > LEN_ONE));
      if (multi) begin
        // The opening request of a burst longer than one beat is never the last.
        exp_last  = in_burst && (beat_cnt_q == LEN_ONE);
        resp_last = bus.MReqLast;
        if (bus.MReqLast != exp_last) perr_d = 1'b1;
        if (bus.MReqLast) begin
          beat_cnt_d = '0;
        end else begin
          state_d = ST_BURST;
          if (!in_burst) begin
            beat_cnt_d = req_len - LEN_ONE;
          end else if (beat_cnt_q != '0) begin
            beat_cnt_d = beat_cnt_q - LEN_ONE;
          end
        end
      end

      case (cmd)
        MCMD_WR: begin
          mem_we = !req_oor;
          // No data handshake exists for single-request write bursts: keep beat 0 only.
          if (bus.MBurstSingleReq && !in_burst) perr_d = 1'b1;
        end
        MCMD_RD: begin
          sresp_d = req_oor ? SRESP_ERR : SRESP_DVA;
          sdata_d = req_oor ? '0 : mem_rdata;
          slast_d = resp_last;
          if (!multi && bus.MBurstSingleReq && (req_len > LEN_ONE)) begin
            state_d    = ST_SRESP;
            beat_cnt_d = req_len - LEN_ONE;
            srq_idx_d  = req_idx + IDX_ONE;
            srq_oor_d  = req_oor;
            slast_d    = 1'b0;
          end
        end
        default: begin
          sresp_d = SRESP_ERR;
          sdata_d = '0;
          slast_d = 1'b1;
        end
      endcase
    end
  end

  assign bus.SCmdAccept = accept;
  assign bus.SResp      = sresp_q;
  assign bus.SData      = sdata_q;
  assign bus.SRespLast  = slast_q;
  assign protocol_err   = perr_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_ocp_slave_fsm.sv
module tb_ocp_slave_fsm;
  import ocp_slave_fsm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ocp_slave_fsm_if #(.MADDR_WIDTH(64), .MDATA_WIDTH(8)) bus0 ();
  ocp_slave_fsm_if #(.MADDR_WIDTH(64), .MDATA_WIDTH(8)) bus1 ();
  logic   perr0, perr1;
  state_e st0, st1;

  ocp_slave_fsm #(.ACCEPT_LATENCY(0)) dut0 (
    .sys_clk(clk), .reset(reset), .bus(bus0), .protocol_err(perr0), .state_dbg(st0)
  );
  ocp_slave_fsm #(.ACCEPT_LATENCY(3)) dut1 (
    .sys_clk(clk), .reset(reset), .bus(bus1), .protocol_err(perr1), .state_dbg(st1)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected response entry: {edge[31:0], sresp[1:0], sdata[7:0], srespLast}
  logic [42:0] exp_q[$];
  logic [7:0]  m_mem [16];
  bit          m_active;   // inside a multi-request burst
  int          m_left;     // requests still announced for that burst
  bit          m_perr;
  int          free_cyc;   // earliest edge at which the slave can accept again

  task automatic push(input int c, input logic [1:0] r, input logic [7:0] d, input logic l);
    exp_q.push_back({c[31:0], r, d, l});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_active = 0;
    m_left   = 0;
    m_perr   = 0;
    free_cyc = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int t, input logic [2:0] cmd, input logic [63:0] addr,
                              input logic [7:0] data, input logic [9:0] blen,
                              input logic srq, input logic last);
    int  len, idx;
    bit  oor, was_active, multi, rlast;
    len        = (blen == 0) ? 1 : int'(blen);
    idx        = int'(addr[5:2]);
    oor        = |addr[63:6];
    was_active = m_active;
    multi      = m_active || (!srq && len > 1);
    rlast      = 1;
    free_cyc   = t + 1;
    if (multi) begin
      if (last != (was_active && m_left == 1)) m_perr = 1;
      rlast = last;
      if (last) m_active = 0;
      else if (was_active) m_left = (m_left > 0) ? m_left - 1 : 0;
      else begin
        m_active = 1;
        m_left   = len - 1;
      end
    end
    case (cmd)
      3'd1: begin
        if (!oor) m_mem[idx] = data;
        if (srq && !was_active) m_perr = 1;
      end
      3'd2: begin
        if (!multi && srq && len > 1) begin
          for (int k = 0; k < len; k++)
            push(t + k, oor ? 2'd3 : 2'd1, oor ? 8'h00 : m_mem[(idx + k) % 16], k == len - 1);
          free_cyc = t + len;
        end else begin
          push(t, oor ? 2'd3 : 2'd1, oor ? 8'h00 : m_mem[idx], rlast);
        end
      end
      default: push(t, 2'd3, 8'h00, 1'b1);
    endcase
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [42:0] e;
    if (!reset) begin
      if (bus0.SResp != 2'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {62'd0, bus0.SResp}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_edge", 64'(cyc), {32'd0, e[42:11]});
          check("sresp", {62'd0, bus0.SResp}, {62'd0, e[10:9]});
          check("sdata", {56'd0, bus0.SData}, {56'd0, e[8:1]});
          check("sresp_last", {63'd0, bus0.SRespLast}, {63'd0, e[0]});
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][42:11]) <= cyc) begin
        e = exp_q.pop_front();
        check("missing_resp", {62'd0, bus0.SResp}, {62'd0, e[10:9]});
      end
      check("protocol_err", {63'd0, perr0}, {63'd0, m_perr});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus0();
    bus0.MCmd = 3'd0; bus0.MAddr = '0; bus0.MData = '0;
    bus0.MBurstLength = 10'd1; bus0.MBurstSingleReq = 1'b0; bus0.MReqLast = 1'b1;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic req(input logic [2:0] cmd, input logic [63:0] addr, input logic [7:0] data,
                     input logic [9:0] blen, input logic srq, input logic last);
    int n, t, exp_edge;
    bit got;
    n        = cyc;
    exp_edge = (n + 1 > free_cyc) ? n + 1 : free_cyc;
    bus0.MCmd = cmd; bus0.MAddr = addr; bus0.MData = data;
    bus0.MBurstLength = blen; bus0.MBurstSingleReq = srq; bus0.MReqLast = last;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus0.SCmdAccept) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", {63'd0, got}, 64'd1);
      idle_bus0();
      return;
    end
    @(posedge clk);
    #1;
    t = cyc;
    check("accept_edge", 64'(t), 64'(exp_edge));
    model_accept(t, cmd, addr, data, blen, srq, last);
    idle_bus0();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sresp"}, {62'd0, bus0.SResp}, 64'd0);
    check({tag, "_sdata"}, {56'd0, bus0.SData}, 64'd0);
    check({tag, "_slast"}, {63'd0, bus0.SRespLast}, 64'd0);
    check({tag, "_accept"}, {63'd0, bus0.SCmdAccept}, 64'd0);
    check({tag, "_perr"}, {63'd0, perr0}, 64'd0);
    check({tag, "_state"}, {62'd0, st0}, {62'd0, ST_IDLE});
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {58'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 7) == 0) a[$urandom_range(6, 63)] = 1'b1;
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] c;
    int len, base, g;
    logic lst;
    idle_bus0();
    bus1.MCmd = 3'd0; bus1.MAddr = '0; bus1.MData = '0;
    bus1.MBurstLength = 10'd1; bus1.MBurstSingleReq = 1'b0; bus1.MReqLast = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: write then read back the same word
    req(3'd1, 64'h4, 8'hFF, 10'd1, 1'b0, 1'b1);
    req(3'd2, 64'h4, 8'h00, 10'd1, 1'b0, 1'b1);

    // 2: accept latency of 3 on the second instance
    bus1.MCmd = 3'd2; bus1.MAddr = 64'h0;
    @(negedge clk); check("lat_abort_c1", {63'd0, bus1.SCmdAccept}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk); check("lat_abort_c2", {63'd0, bus1.SCmdAccept}, 64'd0);
    @(posedge clk); #1 bus1.MCmd = 3'd0;
    @(posedge clk); #1 bus1.MCmd = 3'd2;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("lat_accept_c%0d", k), {63'd0, bus1.SCmdAccept}, (k == 4) ? 64'd1 : 64'd0);
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1 bus1.MCmd = 3'd0;
    @(negedge clk);
    check("lat_sresp", {62'd0, bus1.SResp}, 64'd1);
    check("lat_sdata", {56'd0, bus1.SData}, 64'd0);
    check("lat_slast", {63'd0, bus1.SRespLast}, 64'd1);
    @(negedge clk);
    check("lat_sresp_null", {62'd0, bus1.SResp}, 64'd0);
    @(posedge clk); #1;

    // 3: multi-request write burst then multi-request read burst
    for (int k = 0; k < 4; k++) req(3'd1, 64'(k * 4), 8'(k), 10'd4, 1'b0, k == 3);
    for (int k = 0; k < 4; k++) req(3'd2, 64'(k * 4), 8'h00, 10'd4, 1'b0, k == 3);

    // 4: single-request read burst that wraps, followed by a held request
    req(3'd1, 64'h38, 8'hAE, 10'd1, 1'b0, 1'b1);
    req(3'd1, 64'h3C, 8'hBF, 10'd1, 1'b0, 1'b1);
    req(3'd2, 64'h38, 8'h00, 10'd4, 1'b1, 1'b1);
    req(3'd2, 64'h3C, 8'h00, 10'd1, 1'b0, 1'b1);

    // 5: out-of-range read, RDEX, early MReqLast
    req(3'd2, 64'h100, 8'h00, 10'd1, 1'b0, 1'b1);
    req(3'd3, 64'h0, 8'h00, 10'd1, 1'b0, 1'b1);
    req(3'd1, 64'h0, 8'h11, 10'd4, 1'b0, 1'b0);
    req(3'd1, 64'h4, 8'h22, 10'd4, 1'b0, 1'b1);
    check("burst_end_state", {62'd0, st0}, {62'd0, ST_IDLE});
    req(3'd2, 64'h4, 8'h00, 10'd1, 1'b0, 1'b1);

    // 6: reset during beat 2 of a single-request read burst
    req(3'd1, 64'h10, 8'h5A, 10'd1, 1'b0, 1'b1);
    req(3'd2, 64'h10, 8'h00, 10'd4, 1'b1, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    req(3'd2, 64'h10, 8'h00, 10'd1, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk); #1;
      end
      case ($urandom_range(0, 4))
        0: req(3'd1, rand_addr(), 8'($urandom_range(0, 255)), 10'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), 1'b1);
        1: req(3'd2, rand_addr(), 8'h00, 10'($urandom_range(0, 1)), 1'b0, 1'b1);
        2: begin
          len  = $urandom_range(2, 5);
          base = $urandom_range(0, 15);
          c    = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd2;
          for (int k = 0; k < len; k++) begin
            lst = (k == len - 1);
            if ($urandom_range(0, 15) == 0) lst = !lst;
            req(c, 64'(((base + k) % 16) * 4), 8'($urandom_range(0, 255)), 10'(len), 1'b0, lst);
            if (lst) break;
          end
        end
        3: req(3'd2, rand_addr(), 8'h00, 10'($urandom_range(1, 6)), 1'b1, 1'b1);
        default: req(3'($urandom_range(3, 7)), rand_addr(), 8'h00, 10'd1, 1'b0, 1'b1);
      endcase
    end

    repeat (10) @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
